stage5wb: RTL
=============

STAGE5WB -- requirements
Module: stage5wb

Interface
REQ-001 The module SHALL have exactly one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high, sampled only on the rising edge of clk.
REQ-002 Port list, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- enable_in  in  1  write-back slot valid; comes from the memory-operation stage
- enable_out  out  1  stage accepted the slot this cycle
- pc_in  in  24  PC of the retiring instruction
- instr_in  in  24  retiring instruction; opcode is instr_in[23:16], Rd is instr_in[15:12]
- result_in  in  24  final result; already the load data for LD/LDi
- flags_in  in  4  flags computed by execute
- rd_addr_a  in  4  read port A address
- rd_addr_b  in  4  read port B address
- rd_data_a  out  24  read port A data
- rd_data_b  out  24  read port B data
- fwd_valid  out  1  a register write happens this cycle
- fwd_addr  out  4  register being written this cycle
- fwd_data  out  24  data being written this cycle
- flags_out  out  4  architectural flags register
- retired_count  out  32  number of instructions retired
- last_pc  out  24  PC of the most recently retired instruction
- halted  out  1  core is halted
REQ-003 Opcode names SHALL come from the shared opcode definitions; the block SHALL NOT contain numeric opcode literals.

Function
REQ-004 Define accept = enable_in && !halted; enable_out SHALL equal accept, combinationally.
REQ-005 Define reg_wr = accept && opcode not in {OPC_R_ST, OPC_I_STi, OPC_NOP, OPC_HLT} && Rd != 0.
REQ-006 The register file SHALL hold 16 x 24 bits. On a clock edge with reg_wr, reg[Rd] SHALL be loaded with result_in.
REQ-007 R0 SHALL always read 0; a write to R0 SHALL be dropped and SHALL NOT assert fwd_valid.
REQ-008 Read ports SHALL be combinational with write-through: if reg_wr is true and rd_addr equals Rd (Rd nonzero), that port SHALL return result_in.
REQ-009 fwd_valid SHALL equal reg_wr; fwd_addr SHALL equal Rd and fwd_data SHALL equal result_in, combinationally.
REQ-010 flags_out SHALL load flags_in on any accept whose opcode is not in {OPC_R_ST, OPC_I_STi, OPC_R_LD, OPC_I_LDi, OPC_NOP, OPC_HLT}; otherwise it SHALL hold.
REQ-011 On each accept:
- retired_count SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
- last_pc SHALL load pc_in.
REQ-012 The halt state machine SHALL have two states, RUN and HALTED.
- RUN moves to HALTED on a clock edge where accept is true and the opcode is OPC_HLT.
- HALTED is left only by rst.
REQ-013 The HLT instruction itself SHALL count as retired. halted SHALL be 1 from the cycle after HLT is accepted.
REQ-014 While HALTED, enable_in SHALL be ignored: no register, flag, count or last_pc update, and fwd_valid SHALL be 0.
REQ-015 Read ports SHALL keep working while HALTED.
REQ-016 Latency SHALL be one cycle: state written on edge N SHALL be visible on the registered outputs and read ports after edge N. Same-cycle visibility is provided only by the bypass in REQ-008.

Reset
REQ-017 When rst is high at a clock edge, all of the following SHALL be cleared, overriding any simultaneous accept or HLT:
- all 16 registers to 0
- flags_out to 0
- retired_count to 0
- last_pc to 0
- state to RUN, so halted = 0
REQ-018 During the rst cycle, outputs derived combinationally from the inputs (enable_out, fwd_*, the bypass) MAY be active, but SHALL cause no state change.
REQ-019 Reset asserted mid-operation, including while HALTED, SHALL take effect at the next edge with no residual state.

Verification
REQ-020 After reset: one accepted write of 0x123456 to R5 -> reg5 = 0x123456 on the next cycle, retired_count = 1, fwd_valid pulses for one cycle with fwd_addr = 5.
REQ-021 In the same cycle as a write of 0xABCDEF to R3, rd_addr_a = 3 -> rd_data_a = 0xABCDEF (bypass). Write to R0 -> rd_data = 0 and fwd_valid = 0.
REQ-022 Accepted ST with flags_in = 4'hF -> flags_out unchanged and no register write. Next, an ALU op with flags 4'h5 -> flags_out = 4'h5.
REQ-023 Accepted HLT at pc 0x000040 -> halted = 1 next cycle, last_pc = 0x000040, count incremented once. Further enable_in pulses -> no state change and enable_out = 0.
REQ-024 Preload retired_count to 0xFFFFFFFF via 2^32-1 accepts (or a forced value), then one accept -> retired_count = 0.
REQ-025 rst asserted in the same cycle as an accepted write to R7 while HALTED -> all registers 0, halted = 0, count = 0 after that edge.

Source files
------------

// File: rtl/stage5wb.sv
// stage5wb: write-back stage with 16x24 register file, flags, retire counter, halt FSM.
// Ports: clk/rst, enable_in/out, pc/instr/result/flags in, two read ports, fwd_*, status.

package stage5wb_pkg;
    typedef logic [7:0] opc_t;
    localparam opc_t OPC_NOP    = 8'h00;
    localparam opc_t OPC_R_ADD  = 8'h01;
    localparam opc_t OPC_R_SUB  = 8'h02;
    localparam opc_t OPC_R_AND  = 8'h03;
    localparam opc_t OPC_I_ADDi = 8'h04;
    localparam opc_t OPC_R_LD   = 8'h10;
    localparam opc_t OPC_I_LDi  = 8'h11;
    localparam opc_t OPC_R_ST   = 8'h12;
    localparam opc_t OPC_I_STi  = 8'h13;
    localparam opc_t OPC_HLT    = 8'hFF;
endpackage

module stage5wb
    import stage5wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_in,
    output logic        enable_out,
    input  logic [23:0] pc_in,
    input  logic [23:0] instr_in,
    input  logic [23:0] result_in,
    input  logic [3:0]  flags_in,
    input  logic [3:0]  rd_addr_a,
    input  logic [3:0]  rd_addr_b,
    output logic [23:0] rd_data_a,
    output logic [23:0] rd_data_b,
    output logic        fwd_valid,
    output logic [3:0]  fwd_addr,
    output logic [23:0] fwd_data,
    output logic [3:0]  flags_out,
    output logic [31:0] retired_count,
    output logic [23:0] last_pc,
    output logic        halted
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q;
    logic [23:0] rf_q [16];
    logic [3:0]  flags_q;
    logic [31:0] cnt_q;
    logic [23:0] pc_q;

    opc_t        opcode;
    logic [3:0]  rd;
    logic        accept;
    logic        op_wr;
    logic        op_flags;
    logic        is_hlt;
    logic        reg_wr;
    logic        unused_ok;

    assign opcode    = instr_in[23:16];
    assign rd        = instr_in[15:12];
    assign unused_ok = &{1'b0, instr_in[11:0]};

    // Classify the opcode: does it write a register, does it update flags.
    always_comb begin
        op_wr    = 1'b1;
        op_flags = 1'b1;
        is_hlt   = 1'b0;
        case (opcode)
            OPC_R_ST, OPC_I_STi, OPC_NOP: begin
                op_wr    = 1'b0;
                op_flags = 1'b0;
            end
            OPC_HLT: begin
                op_wr    = 1'b0;
                op_flags = 1'b0;
                is_hlt   = 1'b1;
            end
            OPC_R_LD, OPC_I_LDi: begin
                op_flags = 1'b0;
            end
            default: ;
        endcase
    end

    assign accept     = enable_in && (state_q == RUN);
    assign enable_out = accept;
    assign reg_wr     = accept && op_wr && (rd != 4'd0);

    assign fwd_valid = reg_wr;
    assign fwd_addr  = rd;
    assign fwd_data  = result_in;

    // Combinational read with write-through of the retiring result.
    function automatic logic [23:0] rd_port(input logic [3:0] a);
        if (a == 4'd0)
            return 24'd0;
        else if (reg_wr && (a == rd))
            return result_in;
        else
            return rf_q[a];
    endfunction

    assign rd_data_a = rd_port(rd_addr_a);
    assign rd_data_b = rd_port(rd_addr_b);

    assign flags_out     = flags_q;
    assign retired_count = cnt_q;
    assign last_pc       = pc_q;
    assign halted        = (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                rf_q[i] <= 24'd0;
            flags_q <= 4'd0;
            cnt_q   <= 32'd0;
            pc_q    <= 24'd0;
            state_q <= RUN;
        end else begin
            if (reg_wr)
                rf_q[rd] <= result_in;
            if (accept) begin
                cnt_q <= cnt_q + 32'd1;
                pc_q  <= pc_in;
                if (op_flags)
                    flags_q <= flags_in;
            end
            case (state_q)
                RUN:     if (accept && is_hlt) state_q <= HALTED;
                HALTED:  state_q <= HALTED;
                default: state_q <= RUN;
            endcase
        end
    end

endmodule
